// File: rtl/router_pkg.sv
// Shared definitions for the router output-port reader: FSM state encoding,
// header field positions, port addresses and the strobe-delay bound.
package router_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_HDR_RD,
      S_HDR_CAP,
      S_BODY,
      S_DONE
   } state_e;

   // Header layout: [7:2] payload length, [1:0] destination address
   localparam int LEN_MSB  = 7;
   localparam int LEN_LSB  = 2;
   localparam int ADDR_MSB = 1;
   localparam int ADDR_LSB = 0;

   localparam logic [1:0] ADDR_P0 = 2'd0;
   localparam logic [1:0] ADDR_P1 = 2'd1;
   localparam logic [1:0] ADDR_P2 = 2'd2;

   // Longest strobe delay that still stays clear of the router's 30-cycle
   // unread-timeout soft reset
   localparam int MAX_WAIT = 29;

   // Bytes still to read after the header: payload plus parity byte.
   // Done in 7 bits so len=63 gives 64 without wrapping.
   function automatic logic [6:0] hdr_len_plus1(input logic [7:0] hdr);
      return {1'b0, hdr[LEN_MSB:LEN_LSB]} + 7'd1;
   endfunction

endpackage

// File: rtl/router_parity_chk.sv
// Running XOR over header and payload bytes; compares the trailing parity
// byte against the accumulated value.
module router_parity_chk (
   input  logic       clock,
   input  logic       resetn,
   input  logic       clr_i,
   input  logic       load_i,
   input  logic       acc_i,
   input  logic [7:0] data_i,
   output logic       mismatch_o
);

   logic [7:0] par_q;

   // Accumulator: clear has priority, then load (header), then XOR (payload)
   always_ff @(posedge clock or negedge resetn) begin
      // NOTE: sequential state is written with <= only, so every reader in this
      // clock domain sees the pre-edge value regardless of block ordering.
      if (!resetn) begin
         par_q <= 8'h00;
      end else if (clr_i) begin
         par_q <= 8'h00;
      end else if (load_i) begin
         par_q <= data_i;
      end else if (acc_i) begin
         par_q <= par_q ^ data_i;
      end
   end

   assign mismatch_o = (data_i != par_q);

endmodule

// File: rtl/router_port_reader.sv
// Destination-side reader for one router output port: waits a bounded delay
// after the FIFO goes non-empty, strobes out one packet (header, payload,
// parity), streams the payload and flags address and parity errors.
module router_port_reader
   import router_pkg::*;
#(
   parameter logic [1:0] PORT_ADDR   = ADDR_P0,
   parameter int         WAIT_CYCLES = 4
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       vld_in,
   input  logic [7:0] data_in,
   input  logic       soft_reset_in,
   output logic       read_enb,
   output logic       busy,
   output logic [5:0] pkt_len,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       pkt_done,
   output logic       parity_err,
   output logic       addr_err,
   output logic       abort
);

   localparam int         WCNT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [WCNT_W-1:0] WAIT_LAST =
      (WAIT_CYCLES > 0) ? WCNT_W'(WAIT_CYCLES - 1) : '0;

   state_e            state_q;
   logic [WCNT_W-1:0] wait_cnt_q;
   logic [6:0]        issue_rem_q;   // strobes still to issue after the header
   logic [6:0]        recv_rem_q;    // bytes still to capture after the header
   logic              pend_q;        // a body strobe was issued last cycle
   logic [5:0]        pkt_len_q;
   logic [7:0]        byte_out_q;
   logic              byte_valid_q;
   logic              pkt_done_q;
   logic              parity_err_q;
   logic              addr_err_q;
   logic              abort_q;

   logic rd_strobe;
   logic sr_hit;
   logic capture;
   logic par_load;
   logic par_acc;
   logic par_mismatch;

   // Read strobe: only in HDR_RD/BODY, only with data available; a soft reset
   // in the same cycle suppresses it
   always_comb begin
      // NOTE: default assignment first so no path leaves rd_strobe unassigned
      // (which would infer a latch).
      rd_strobe = 1'b0;
      if (!soft_reset_in) begin
         case (state_q)
            S_HDR_RD: rd_strobe = vld_in;
            S_BODY:   rd_strobe = vld_in && (issue_rem_q != 7'd0);
            default:  rd_strobe = 1'b0;
         endcase
      end
   end

   assign sr_hit   = soft_reset_in && (state_q != S_IDLE);
   assign capture  = (state_q == S_BODY) && pend_q && !soft_reset_in;
   assign par_load = (state_q == S_HDR_CAP) && !soft_reset_in;
   assign par_acc  = capture && (recv_rem_q > 7'd1);

   router_parity_chk u_parity (
      .clock      (clock),
      .resetn     (resetn),
      .clr_i      (sr_hit),
      .load_i     (par_load),
      .acc_i      (par_acc),
      .data_i     (data_in),
      .mismatch_o (par_mismatch)
   );

   // Packet-drain FSM with all status outputs registered
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         wait_cnt_q   <= '0;
         issue_rem_q  <= 7'd0;
         recv_rem_q   <= 7'd0;
         pend_q       <= 1'b0;
         pkt_len_q    <= 6'd0;
         byte_out_q   <= 8'h00;
         byte_valid_q <= 1'b0;
         pkt_done_q   <= 1'b0;
         parity_err_q <= 1'b0;
         addr_err_q   <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         byte_valid_q <= 1'b0;
         pkt_done_q   <= 1'b0;
         abort_q      <= 1'b0;
         if (sr_hit) begin
            state_q      <= S_IDLE;
            abort_q      <= 1'b1;
            wait_cnt_q   <= '0;
            issue_rem_q  <= 7'd0;
            recv_rem_q   <= 7'd0;
            pend_q       <= 1'b0;
            parity_err_q <= 1'b0;
            addr_err_q   <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (vld_in) begin
                     wait_cnt_q <= '0;
                     state_q    <= (WAIT_CYCLES == 0) ? S_HDR_RD : S_WAIT;
                  end
               end
               S_WAIT: begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
                  if (wait_cnt_q == WAIT_LAST) state_q <= S_HDR_RD;
               end
               S_HDR_RD: begin
                  if (rd_strobe) state_q <= S_HDR_CAP;
               end
               S_HDR_CAP: begin
                  pkt_len_q   <= data_in[LEN_MSB:LEN_LSB];
                  addr_err_q  <= (data_in[ADDR_MSB:ADDR_LSB] != PORT_ADDR);
                  issue_rem_q <= hdr_len_plus1(data_in);
                  recv_rem_q  <= hdr_len_plus1(data_in);
                  pend_q      <= 1'b0;
                  state_q     <= S_BODY;
               end
               S_BODY: begin
                  pend_q <= rd_strobe;
                  if (rd_strobe) issue_rem_q <= issue_rem_q - 7'd1;
                  if (capture) begin
                     recv_rem_q <= recv_rem_q - 7'd1;
                     if (recv_rem_q > 7'd1) begin
                        byte_out_q   <= data_in;
                        byte_valid_q <= 1'b1;
                     end else begin
                        parity_err_q <= par_mismatch;
                        pkt_done_q   <= 1'b1;
                        state_q      <= S_DONE;
                     end
                  end
               end
               S_DONE: begin
                  parity_err_q <= 1'b0;
                  addr_err_q   <= 1'b0;
                  state_q      <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign read_enb   = rd_strobe;
   assign busy       = (state_q != S_IDLE);
   assign pkt_len    = pkt_len_q;
   assign byte_out   = byte_out_q;
   assign byte_valid = byte_valid_q;
   assign pkt_done   = pkt_done_q;
   assign parity_err = parity_err_q;
   assign addr_err   = addr_err_q;
   assign abort      = abort_q;

endmodule

// File: tb/tb_router_port_reader.sv
// Bench for router_port_reader: a queue models the port FIFO, a scoreboard
// holds expected payload bytes and end-of-packet status.
module tb_router_port_reader;

   logic       clock = 1'b0;
   logic       resetn;
   logic       vld_in;
   logic [7:0] data_in;
   logic       soft_reset_in;
   logic       read_enb;
   logic       busy;
   logic [5:0] pkt_len;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       pkt_done;
   logic       parity_err;
   logic       addr_err;
   logic       abort;

   router_port_reader #(
      .PORT_ADDR   (2'd1),
      .WAIT_CYCLES (4)
   ) dut (
      .clock         (clock),
      .resetn        (resetn),
      .vld_in        (vld_in),
      .data_in       (data_in),
      .soft_reset_in (soft_reset_in),
      .read_enb      (read_enb),
      .busy          (busy),
      .pkt_len       (pkt_len),
      .byte_out      (byte_out),
      .byte_valid    (byte_valid),
      .pkt_done      (pkt_done),
      .parity_err    (parity_err),
      .addr_err      (addr_err),
      .abort         (abort)
   );

   initial forever #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int total = 0;
   int bad   = 0;

   logic [7:0] fifo[$];
   logic [7:0] exp_bytes[$];
   logic [7:0] exp_done[$];   // {len[5:0], parity_err, addr_err}

   int cyc = 0;
   int n_strobes = 0;
   int n_bv = 0;
   int n_done = 0;
   int n_abort = 0;
   int rise_cyc = 0;
   int first_rd_cyc = 0;
   bit rd_seen = 0;
   bit vld_prev = 0;
   int stall_after = -1;
   int stall_cnt = 0;
   int gap_cycles = 0;
   int gap_strobes = 0;
   bit abort_armed = 0;
   int abort_at_bv = 0;
   bit sr_fired = 0;
   bit sr_clear = 0;
   bit flush_pending = 0;

   // One clock cycle: observe at the falling edge, update FIFO outputs just after the rising edge
   task automatic tick();
      logic       rd;
      logic [7:0] rd_val;
      logic [7:0] e;
      @(negedge clock);
      cyc++;
      if (sr_clear) begin
         soft_reset_in = 1'b0;
         sr_clear = 1'b0;
      end
      if (byte_valid === 1'b1) begin
         n_bv++;
         total++;
         if (exp_bytes.size() == 0) begin
            bad++;
            $display("FAIL stray_byte: got byte_out=%02h, required no byte_valid", byte_out);
         end else begin
            e = exp_bytes.pop_front();
            if (byte_out !== e) begin
               bad++;
               $display("FAIL payload_byte: got %02h, required %02h", byte_out, e);
            end
         end
      end
      if (pkt_done === 1'b1) begin
         n_done++;
         total++;
         if (exp_done.size() == 0) begin
            bad++;
            $display("FAIL stray_pkt_done: got pkt_done, required none");
         end else begin
            e = exp_done.pop_front();
            if ({pkt_len, parity_err, addr_err} !== e) begin
               bad++;
               $display("FAIL done_status: got len=%0d perr=%0b aerr=%0b, required len=%0d perr=%0b aerr=%0b",
                        pkt_len, parity_err, addr_err, e[7:2], e[1], e[0]);
            end
         end
      end
      if (abort === 1'b1) n_abort++;
      if (abort_armed && n_bv == abort_at_bv) begin
         soft_reset_in = 1'b1;
         flush_pending = 1'b1;
         abort_armed   = 1'b0;
         sr_fired      = 1'b1;
         sr_clear      = 1'b1;
      end
      if (vld_in && !vld_prev) begin
         rise_cyc = cyc;
         rd_seen  = 1'b0;
      end
      vld_prev = vld_in;
      rd = read_enb;
      rd_val = 8'h00;
      if (stall_cnt > 0) begin
         gap_cycles++;
         if (rd) gap_strobes++;
      end
      if (rd) begin
         n_strobes++;
         total++;
         if (vld_in !== 1'b1) begin
            bad++;
            $display("FAIL strobe_vld: got read_enb=1 with vld_in=%0b, required vld_in=1", vld_in);
         end
         if (!rd_seen) begin
            first_rd_cyc = cyc;
            rd_seen = 1'b1;
         end
         if (fifo.size() > 0) rd_val = fifo.pop_front();
      end
      @(posedge clock);
      #1;
      if (rd) data_in = rd_val;
      if (flush_pending) begin
         fifo.delete();
         flush_pending = 1'b0;
      end
      if (stall_cnt > 0) stall_cnt--;
      if (stall_after >= 0 && n_strobes == stall_after) begin
         stall_cnt   = 3;
         stall_after = -1;
      end
      vld_in = (fifo.size() != 0) && (stall_cnt == 0);
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_packet(input logic [7:0] hdr, input logic [7:0] pl[$], input bit corrupt);
      logic [7:0] par;
      par = hdr;
      foreach (pl[i]) par ^= pl[i];
      fifo.push_back(hdr);
      foreach (pl[i]) begin
         fifo.push_back(pl[i]);
         exp_bytes.push_back(pl[i]);
      end
      fifo.push_back(corrupt ? ~par : par);
      exp_done.push_back({hdr[7:2], corrupt, (hdr[1:0] != 2'd1)});
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      int n = 0;
      while (n_done < target && n < budget) begin
         tick();
         n++;
      end
      total++;
      if (n_done < target) begin
         bad++;
         $display("FAIL %s_timeout: got pkt_done count %0d, required %0d", name, n_done, target);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      soft_reset_in = 1'b0;
      vld_in = 1'b0;
      data_in = 8'h00;
      repeat (3) @(negedge clock);
      total++;
      if ({busy, read_enb, byte_valid, pkt_done, parity_err, addr_err, abort, pkt_len, byte_out} !== 21'd0) begin
         bad++;
         $display("FAIL reset_outputs: got busy=%0b re=%0b bv=%0b done=%0b perr=%0b aerr=%0b abort=%0b len=%0d byte=%02h, required all 0",
                  busy, read_enb, byte_valid, pkt_done, parity_err, addr_err, abort, pkt_len, byte_out);
      end
      resetn = 1'b1;
      idle(3);
      total++;
      if (busy !== 1'b0 || read_enb !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_reset: got busy=%0b read_enb=%0b, required 0 0", busy, read_enb);
      end
   endtask

   task automatic test_basic();
      logic [7:0] pl[$];
      int bv0, d0;
      pl = '{8'hA1, 8'hB2, 8'hC3};
      bv0 = n_bv;
      d0  = n_done;
      send_packet(8'h0D, pl, 1'b0);
      wait_done(d0 + 1, 100, "basic");
      total++;
      if (first_rd_cyc - rise_cyc !== 5) begin
         bad++;
         $display("FAIL strobe_latency: got %0d cycles, required 5", first_rd_cyc - rise_cyc);
      end
      total++;
      if (n_bv - bv0 !== 3) begin
         bad++;
         $display("FAIL basic_byte_count: got %0d, required 3", n_bv - bv0);
      end
      total++;
      if (pkt_len !== 6'd3) begin
         bad++;
         $display("FAIL basic_pkt_len: got %0d, required 3", pkt_len);
      end
      idle(3);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL basic_busy_after: got %0b, required 0", busy);
      end
   endtask

   task automatic test_parity_err();
      logic [7:0] pl[$];
      int bv0, d0;
      pl = '{8'hA1, 8'hB2, 8'hC3};
      bv0 = n_bv;
      d0  = n_done;
      send_packet(8'h0D, pl, 1'b1);
      wait_done(d0 + 1, 100, "parity_err");
      total++;
      if (n_bv - bv0 !== 3) begin
         bad++;
         $display("FAIL parity_err_byte_count: got %0d, required 3", n_bv - bv0);
      end
      idle(3);
   endtask

   task automatic test_addr_err();
      logic [7:0] pl[$];
      int bv0, d0;
      pl = '{8'h11, 8'h22, 8'h33};
      bv0 = n_bv;
      d0  = n_done;
      send_packet(8'h0E, pl, 1'b0);
      wait_done(d0 + 1, 100, "addr_err");
      total++;
      if (n_bv - bv0 !== 3) begin
         bad++;
         $display("FAIL addr_err_byte_count: got %0d, required 3", n_bv - bv0);
      end
      idle(3);
   endtask

   task automatic test_len0();
      logic [7:0] pl[$];
      int bv0, d0, s0;
      bv0 = n_bv;
      d0  = n_done;
      s0  = n_strobes;
      send_packet(8'h00, pl, 1'b0);
      wait_done(d0 + 1, 100, "len0");
      idle(3);
      total++;
      if (n_strobes - s0 !== 2) begin
         bad++;
         $display("FAIL len0_strobes: got %0d, required 2", n_strobes - s0);
      end
      total++;
      if (n_bv - bv0 !== 0) begin
         bad++;
         $display("FAIL len0_bytes: got %0d, required 0", n_bv - bv0);
      end
   endtask

   task automatic test_len63_stall();
      logic [7:0] pl[$];
      int bv0, d0, s0;
      for (int i = 0; i < 63; i++) pl.push_back(8'($urandom_range(0, 255)));
      bv0 = n_bv;
      d0  = n_done;
      s0  = n_strobes;
      gap_cycles  = 0;
      gap_strobes = 0;
      stall_after = s0 + 11;   // header plus ten payload strobes
      send_packet(8'hFD, pl, 1'b0);
      wait_done(d0 + 1, 400, "len63");
      idle(4);
      total++;
      if (gap_cycles !== 3 || gap_strobes !== 0) begin
         bad++;
         $display("FAIL len63_gap: got %0d gap cycles with %0d strobes, required 3 with 0",
                  gap_cycles, gap_strobes);
      end
      total++;
      if (n_bv - bv0 !== 63) begin
         bad++;
         $display("FAIL len63_bytes: got %0d, required 63", n_bv - bv0);
      end
      total++;
      if (n_done - d0 !== 1) begin
         bad++;
         $display("FAIL len63_done_count: got %0d, required 1", n_done - d0);
      end
   endtask

   task automatic test_abort();
      logic [7:0] pl[$];
      logic [7:0] par;
      int a0, d0, s0, n;
      pl  = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E};
      par = 8'h15;
      fifo.push_back(8'h15);
      foreach (pl[i]) begin
         fifo.push_back(pl[i]);
         par ^= pl[i];
      end
      fifo.push_back(par);
      exp_bytes.push_back(pl[0]);
      exp_bytes.push_back(pl[1]);
      a0 = n_abort;
      d0 = n_done;
      sr_fired    = 1'b0;
      abort_at_bv = n_bv + 2;
      abort_armed = 1'b1;
      n = 0;
      while (!sr_fired && n < 200) begin
         tick();
         n++;
      end
      total++;
      if (!sr_fired) begin
         bad++;
         abort_armed = 1'b0;
         $display("FAIL abort_trigger_timeout: got %0d payload bytes, required 2", n_bv);
      end
      total++;
      if (abort !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL abort_pulse: got abort=%0b busy=%0b, required 1 0", abort, busy);
      end
      s0 = n_strobes;
      idle(10);
      total++;
      if (n_strobes !== s0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL abort_quiet: got %0d strobes busy=%0b, required 0 strobes busy=0",
                  n_strobes - s0, busy);
      end
      total++;
      if (n_abort - a0 !== 1 || n_done !== d0) begin
         bad++;
         $display("FAIL abort_counts: got aborts=%0d dones=%0d, required 1 0", n_abort - a0, n_done - d0);
      end
      // A fresh packet after the abort must be picked up from IDLE
      pl = '{8'hC0, 8'hDE};
      send_packet(8'h09, pl, 1'b0);
      wait_done(d0 + 1, 100, "after_abort");
      idle(3);
   endtask

   task automatic test_back_to_back();
      logic [7:0] pl[$];
      int d0, bv0;
      d0  = n_done;
      bv0 = n_bv;
      pl = '{8'h01, 8'h02};
      send_packet(8'h09, pl, 1'b0);
      pl = '{8'hF0, 8'hE1, 8'hD2, 8'hC3};
      send_packet(8'h11, pl, 1'b0);
      wait_done(d0 + 2, 200, "back_to_back");
      idle(3);
      total++;
      if (n_bv - bv0 !== 6) begin
         bad++;
         $display("FAIL b2b_bytes: got %0d, required 6", n_bv - bv0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity_err();
      test_addr_err();
      test_len0();
      test_len63_stall();
      test_abort();
      test_back_to_back();
      total++;
      if (exp_bytes.size() != 0 || exp_done.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d bytes and %0d packets outstanding, required 0 0",
                  exp_bytes.size(), exp_done.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
